i2s_capture_ctrl: RTL
=====================

// Module: i2s_capture_ctrl
// PURPOSE
//  Sequences the I2S ADC receiver for the spectrum analyzer front end: arms the receiver,
//  collects each stereo sample pair and reduces it per mode (L, R, mix or interleave).
//  Writes the results into a two-bank (ping-pong) frame buffer of FRAME_LEN words.
//  Hands completed frames to the FFT consumer via a valid/ack handshake and counts overruns.
// PARAMETERS
//  DATA_BITS  16   width of one audio sample (matches receiver)
//  FRAME_LEN  256  words per frame per bank; power of 2, >=4; even required for mode 3
//  OVR_BITS   8    width of saturating overrun counter
//  (localparam ADDR_BITS = $clog2(FRAME_LEN))
// PORTS
//  codec_aud_bclk_i     in   1            clock (codec bit clock)
//  rst_n                in   1            synchronous reset, active-low
//  enable_i             in   1            capture enable
//  mode_i               in   2            0=L 1=R 2=(L+R)/2 3=interleaved L,R
//  i2s_get_o            out  1            arm request to receiver
//  i2s_done_i           in   1            receiver stereo-sample-complete flag
//  i2s_sample_data_L_i  in   DATA_BITS    receiver left sample (signed)
//  i2s_sample_data_R_i  in   DATA_BITS    receiver right sample (signed)
//  buf_wr_en_o          out  1            frame buffer write strobe
//  buf_wr_addr_o        out  ADDR_BITS+1  {bank, index}
//  buf_wr_data_o        out  DATA_BITS    word written
//  frame_valid_o        out  1            a full bank awaits consumer
//  frame_bank_o         out  1            bank index offered to consumer
//  frame_ack_i          in   1            consumer done with frame_bank_o (1-cycle pulse)
//  overrun_cnt_o        out  OVR_BITS     dropped-sample count, saturating
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): all outputs 0, state IDLE, wr_bank=0, rd_bank=0, idx=0, bank_full=2'b00.
//  - All outputs registered. done_rise = i2s_done_i & ~done_q (done_q is i2s_done_i delayed one edge).
//  - FSM: IDLE -> ARM when enable_i. ARM: i2s_get_o<=1 -> WAIT. WAIT: on done_rise latch L,R -> WR0.
//    WR0: one write; mode 3 -> WR1 (second write) -> WAIT; otherwise -> WAIT.
//  - mode_q <= mode_i only when idx==0 on the ARM/WAIT->WR0 transition; a frame never mixes modes.
//  - Write data: 0:L, 1:R, 2:(sext(L)+sext(R))>>>1 in DATA_BITS+1 (floor), 3:L at idx then R at idx+1.
//  - Latency: buf_wr_en_o high exactly one cycle (two consecutive in mode 3), starting the edge after done_rise.
//  - buf_wr_addr_o = {wr_bank, idx}; idx increments per write and wraps to 0 after FRAME_LEN-1.
//  - Frame complete (write at idx=FRAME_LEN-1): next edge sets bank_full[wr_bank] and toggles wr_bank.
//  - frame_valid_o = bank_full[rd_bank]; frame_bank_o = rd_bank.
//    frame_ack_i while valid: clear bank_full[rd_bank], toggle rd_bank. Ack while not valid: ignored.
//  - Overrun: done_rise with bank_full[wr_bank]=1 means the pair is dropped, no write, overrun_cnt_o+1 (saturate at all-ones).
//  - Simultaneous frame complete and ack: both apply in the same edge; two full banks remain legal.
//  - enable_i=0 in any state: next edge i2s_get_o<=0, state IDLE, idx<=0 (partial frame discarded).
//    An in-flight WR0/WR1 write is aborted. bank_full, rd_bank, wr_bank and overrun_cnt_o are preserved.
//  - done_rise while in WR0/WR1: cannot occur at legal rates (>=32 bclk per pair); the pair is dropped with no overrun count.
// STRUCTURE
//  - Shared package i2s_pkg: mode encodings (MODE_L/R/MIX/ILV) and FSM state encoding.
//  - One sub-module, i2s_bank_tracker: bank_full[1:0], rd_bank, frame handshake and overrun counter.
//  - FSM, mixing datapath and address generation stay in i2s_capture_ctrl.
// TESTING (bench: FRAME_LEN=4, DATA_BITS=16)
//  - Mode 2, pairs L=0x0004,R=0x0002 x4 -> writes addr 0..3 data 0x0003; frame_valid_o=1, frame_bank_o=0.
//  - Mode 2, L=0x8000, R=0xFFFF -> data 0xBFFF (floor); L=0x7FFF, R=0x7FFF -> 0x7FFF, no wrap.
//  - Mode 3, 2 pairs (1,2),(3,4) -> addr 0..3 data 1,2,3,4, back-to-back strobe pairs; bank 0 full.
//  - No ack, 12 pairs in mode 0 -> banks 0,1 full, then 4 drops, overrun_cnt_o=4.
//    Ack -> frame_bank_o 0->1; next pair lands at addr {0,0}.
//  - enable_i dropped after 2 writes, re-raised -> i2s_get_o low one+ cycle; next write at idx 0, same bank.
//  - rst_n low mid-frame with bank 0 full -> all outputs 0 next edge, frame_valid_o=0, overrun_cnt_o=0.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared encodings for the I2S capture path: reduction modes and capture FSM states.
package i2s_pkg;

    typedef enum logic [1:0] {
        MODE_L   = 2'd0,
        MODE_R   = 2'd1,
        MODE_MIX = 2'd2,
        MODE_ILV = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR0  = 3'd3,
        ST_WR1  = 3'd4
    } state_e;

endpackage

// File: rtl/i2s_bank_tracker.sv
// Ping-pong bank ownership: full flags, consumer-side bank pointer, frame handshake, overrun count.
// Registered outputs; an ack that arrives while no frame is offered is ignored.
module i2s_bank_tracker #(
    parameter int OVR_BITS = 8
) (
    input  logic                codec_aud_bclk_i,
    input  logic                rst_n,
    input  logic                frame_done_i,
    input  logic                wr_bank_i,
    input  logic                frame_ack_i,
    input  logic                overrun_i,
    output logic [1:0]          bank_full_o,
    output logic                frame_valid_o,
    output logic                frame_bank_o,
    output logic [OVR_BITS-1:0] overrun_cnt_o
);

    logic [1:0]          full_q, full_d;
    logic                rd_q, rd_d;
    logic                valid_q;
    logic [OVR_BITS-1:0] ovr_q, ovr_d;

    // Fill and drain may hit the two different banks in the same edge.
    always_comb begin
        full_d = full_q;
        rd_d   = rd_q;
        ovr_d  = ovr_q;
        if (frame_done_i) begin
            full_d[wr_bank_i] = 1'b1;
        end
        if (frame_ack_i && full_q[rd_q]) begin
            full_d[rd_q] = 1'b0;
            rd_d         = ~rd_q;
        end
        if (overrun_i && (ovr_q != {OVR_BITS{1'b1}})) begin
            ovr_d = ovr_q + 1'b1;
        end
    end

    always_ff @(posedge codec_aud_bclk_i) begin
        if (!rst_n) begin
            full_q  <= 2'b00;
            rd_q    <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= '0;
        end else begin
            full_q  <= full_d;
            rd_q    <= rd_d;
            valid_q <= full_d[rd_d];
            ovr_q   <= ovr_d;
        end
    end

    assign bank_full_o   = full_q;
    assign frame_valid_o = valid_q;
    assign frame_bank_o  = rd_q;
    assign overrun_cnt_o = ovr_q;

endmodule

// File: rtl/i2s_capture_ctrl.sv
// Arms the I2S receiver, reduces each stereo pair per mode and fills a ping-pong frame buffer.
// Write strobe one edge after the pair is latched; pairs arriving into a full bank are dropped and counted.
module i2s_capture_ctrl
    import i2s_pkg::*;
#(
    parameter int DATA_BITS = 16,
    parameter int FRAME_LEN = 256,
    parameter int OVR_BITS  = 8,
    localparam int ADDR_BITS = $clog2(FRAME_LEN)
) (
    input  logic                 codec_aud_bclk_i,
    input  logic                 rst_n,
    input  logic                 enable_i,
    input  logic [1:0]           mode_i,
    output logic                 i2s_get_o,
    input  logic                 i2s_done_i,
    input  logic [DATA_BITS-1:0] i2s_sample_data_L_i,
    input  logic [DATA_BITS-1:0] i2s_sample_data_R_i,
    output logic                 buf_wr_en_o,
    output logic [ADDR_BITS:0]   buf_wr_addr_o,
    output logic [DATA_BITS-1:0] buf_wr_data_o,
    output logic                 frame_valid_o,
    output logic                 frame_bank_o,
    input  logic                 frame_ack_i,
    output logic [OVR_BITS-1:0]  overrun_cnt_o
);

    localparam logic [ADDR_BITS-1:0] IDX_LAST = ADDR_BITS'(FRAME_LEN - 1);

    state_e                 state_q, state_d;
    mode_e                  mode_q, mode_d;
    logic                   done_q;
    logic                   done_rise;
    logic [DATA_BITS-1:0]   l_q, l_d, r_q, r_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic                   wr_bank_q, wr_bank_d;
    logic                   get_q, get_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_BITS:0]     addr_q, addr_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   frame_done;
    logic                   overrun;
    logic [1:0]             bank_full;
    logic signed [DATA_BITS:0] mix_sum;
    logic [DATA_BITS-1:0]   mix_dat;

    assign done_rise = i2s_done_i & ~done_q;

    // One extra bit of headroom makes the average exact; >>> floors toward -inf.
    assign mix_sum = $signed({l_q[DATA_BITS-1], l_q}) + $signed({r_q[DATA_BITS-1], r_q});
    assign mix_dat = DATA_BITS'(mix_sum >>> 1);

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        l_d        = l_q;
        r_d        = r_q;
        idx_d      = idx_q;
        wr_bank_d  = wr_bank_q;
        get_d      = get_q;
        wr_en_d    = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        frame_done = 1'b0;
        overrun    = 1'b0;
        if (!enable_i) begin
            state_d = ST_IDLE;
            get_d   = 1'b0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARM;
                ST_ARM, ST_WAIT: begin
                    get_d   = 1'b1;
                    state_d = ST_WAIT;
                    if (done_rise) begin
                        if (bank_full[wr_bank_q]) begin
                            overrun = 1'b1;
                        end else begin
                            l_d     = i2s_sample_data_L_i;
                            r_d     = i2s_sample_data_R_i;
                            state_d = ST_WR0;
                            if (idx_q == '0) begin
                                mode_d = mode_e'(mode_i);
                            end
                        end
                    end
                end
                ST_WR0, ST_WR1: begin
                    wr_en_d = 1'b1;
                    addr_d  = {wr_bank_q, idx_q};
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_WAIT;
                    if (state_q == ST_WR1) begin
                        data_d = r_q;
                    end else begin
                        case (mode_q)
                            MODE_L:   data_d = l_q;
                            MODE_R:   data_d = r_q;
                            MODE_MIX: data_d = mix_dat;
                            default: begin
                                data_d  = l_q;
                                state_d = ST_WR1;
                            end
                        endcase
                    end
                    if (idx_q == IDX_LAST) begin
                        frame_done = 1'b1;
                        wr_bank_d  = ~wr_bank_q;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge codec_aud_bclk_i) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_L;
            done_q    <= 1'b0;
            l_q       <= '0;
            r_q       <= '0;
            idx_q     <= '0;
            wr_bank_q <= 1'b0;
            get_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            done_q    <= i2s_done_i;
            l_q       <= l_d;
            r_q       <= r_d;
            idx_q     <= idx_d;
            wr_bank_q <= wr_bank_d;
            get_q     <= get_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    i2s_bank_tracker #(
        .OVR_BITS(OVR_BITS)
    ) u_bank_tracker (
        .codec_aud_bclk_i(codec_aud_bclk_i),
        .rst_n           (rst_n),
        .frame_done_i    (frame_done),
        .wr_bank_i       (wr_bank_q),
        .frame_ack_i     (frame_ack_i),
        .overrun_i       (overrun),
        .bank_full_o     (bank_full),
        .frame_valid_o   (frame_valid_o),
        .frame_bank_o    (frame_bank_o),
        .overrun_cnt_o   (overrun_cnt_o)
    );

    assign i2s_get_o     = get_q;
    assign buf_wr_en_o   = wr_en_q;
    assign buf_wr_addr_o = addr_q;
    assign buf_wr_data_o = data_q;

endmodule
